// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: turns the raw push-button and run-mode switch into a clean,
// fixed-width step clock for the CPU core, with single-step and auto modes.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | step_clk low, not busy; waits for a step request
//   HIGH  | step_clk high for PULSE_CYCLES cycles (pulse on first cycle)
//   LOW   | step_clk low for PULSE_CYCLES cycles, still busy
module cpu_step_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int PULSE_CYCLES    = 4,
   parameter int AUTO_DIV        = 25000000,
   parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        button_in,
   input  logic        run_mode,
   input  logic        halt_in,
   output logic        step_clk,
   output logic        step_pulse,
   output logic [15:0] step_count,
   output logic        busy,
   output logic        btn_level
);

   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int AW = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
   localparam int TW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_DIV - 1);
   localparam logic [TW-1:0] T_LOAD    = TW'(PULSE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   state_t          state;
   logic [TW-1:0]   tmr;
   logic            btn_s1, btn_s2;
   logic            mode_s1, mode_s2;
   logic [DW-1:0]   db_cnt;
   logic            press_evt;
   logic [AW-1:0]   auto_cnt;
   logic            auto_evt;
   logic            req;

   // Two-flop synchronisers; the button is normalised to 1 = pressed first so
   // the reset value of the chain reads as released.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         btn_s1  <= 1'b0;
         btn_s2  <= 1'b0;
         mode_s1 <= 1'b0;
         mode_s2 <= 1'b0;
      end else begin
         btn_s1  <= button_in ^ BTN_ACTIVE_LOW;
         btn_s2  <= btn_s1;
         mode_s1 <= run_mode;
         mode_s2 <= mode_s1;
      end
   end

   // Debounce: accept a new level only after DEBOUNCE_CYCLES differing samples.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         db_cnt    <= '0;
         btn_level <= 1'b0;
         press_evt <= 1'b0;
      end else begin
         press_evt <= 1'b0;
         if (btn_s2 == btn_level) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            db_cnt    <= '0;
            btn_level <= ~btn_level;
            press_evt <= ~btn_level;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   // Auto-mode divider, parked at zero whenever single-step mode is selected.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         auto_cnt <= '0;
      end else if (!mode_s2 || auto_cnt == AUTO_LAST) begin
         auto_cnt <= '0;
      end else begin
         auto_cnt <= auto_cnt + 1'b1;
      end
   end

   assign auto_evt = mode_s2 && (auto_cnt == AUTO_LAST);
   assign req      = (press_evt && !mode_s2) || (auto_evt && !halt_in);

   // Step waveform FSM; tmr is a down-counter reloaded on each phase entry.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         tmr        <= '0;
         step_clk   <= 1'b0;
         step_pulse <= 1'b0;
         busy       <= 1'b0;
         step_count <= '0;
      end else begin
         step_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  state      <= HIGH;
                  tmr        <= T_LOAD;
                  step_clk   <= 1'b1;
                  step_pulse <= 1'b1;
                  busy       <= 1'b1;
                  step_count <= step_count + 16'd1;
               end
            end
            HIGH: begin
               if (tmr == '0) begin
                  state    <= LOW;
                  tmr      <= T_LOAD;
                  step_clk <= 1'b0;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            LOW: begin
               if (tmr == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               step_clk <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: directed phases with randomized segments, checked
// cycle by cycle against a behavioural model of the step controller.
module tb_cpu_step_ctrl;

   localparam int D = 4;
   localparam int P = 2;
   localparam int A = 10;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        button_in;
   logic        run_mode;
   logic        halt_in;
   logic        step_clk;
   logic        step_pulse;
   logic [15:0] step_count;
   logic        busy;
   logic        btn_level;

   int checks = 0;
   int errors = 0;
   int npulse = 0;

   cpu_step_ctrl #(
      .DEBOUNCE_CYCLES(D),
      .PULSE_CYCLES(P),
      .AUTO_DIV(A),
      .BTN_ACTIVE_LOW(1'b1)
   ) dut (
      .CLK(CLK),
      .Reset(Reset),
      .button_in(button_in),
      .run_mode(run_mode),
      .halt_in(halt_in),
      .step_clk(step_clk),
      .step_pulse(step_pulse),
      .step_count(step_count),
      .busy(busy),
      .btn_level(btn_level)
   );

   always #5 CLK = ~CLK;

   // Reference model: synchroniser history, stable-run debounce, cycles spent
   // in auto mode, and the position within the 2*P-cycle step waveform.
   bit          m_b1, m_b2, m_m1, m_m2;
   bit          m_level, m_press;
   int          m_run, m_age, m_t;
   logic [15:0] m_cnt;

   task automatic model_reset();
      m_b1 = 0; m_b2 = 0; m_m1 = 0; m_m2 = 0;
      m_level = 0; m_press = 0;
      m_run = 0; m_age = 0; m_t = 0;
      m_cnt = 16'h0000;
   endtask

   task automatic model_step();
      bit aevt, req, new_press;
      if (Reset) begin
         model_reset();
         return;
      end
      aevt = m_m2 && ((m_age % A) == A - 1);
      req  = (m_press && !m_m2) || (aevt && !halt_in);
      if (m_t == 0) begin
         if (req) begin
            m_t   = 1;
            m_cnt = m_cnt + 16'd1;
         end
      end else begin
         m_t = (m_t == 2 * P) ? 0 : m_t + 1;
      end
      m_run = (m_b2 != m_level) ? m_run + 1 : 0;
      new_press = 0;
      if (m_run == D) begin
         m_level   = !m_level;
         m_run     = 0;
         new_press = m_level;
      end
      m_press = new_press;
      m_age   = m_m2 ? m_age + 1 : 0;
      m_b2 = m_b1;
      m_b1 = !button_in;
      m_m2 = m_m1;
      m_m1 = run_mode;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("step_clk",   32'(step_clk),   32'(m_t >= 1 && m_t <= P));
      chk("step_pulse", 32'(step_pulse), 32'(m_t == 1));
      chk("busy",       32'(busy),       32'(m_t != 0));
      chk("btn_level",  32'(btn_level),  32'(m_level));
      chk("step_count", 32'(step_count), 32'(m_cnt));
   endtask

   task automatic tick();
      @(posedge CLK);
      model_step();
      #1;
      if (step_pulse === 1'b1) npulse++;
      check_all();
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   initial begin
      logic [15:0] c0;
      int          d;
      int          len;
      bit          seen;

      Reset = 1'b1; button_in = 1'b1; run_mode = 1'b0; halt_in = 1'b0;
      model_reset();
      ticks(3);
      Reset = 1'b0;

      // Idle after reset: everything stays low.
      ticks(50);
      chk("reset_idle_count", 32'(step_count), 32'h0);

      // Single step from a held press.
      button_in = 1'b0;
      ticks(20);
      chk("single_step_count", 32'(step_count), 32'h1);
      button_in = 1'b1;
      ticks(12);

      // Bounce shorter than the debounce window.
      c0 = m_cnt;
      for (int i = 0; i < 20; i++) begin
         button_in = ~button_in;
         tick();
      end
      button_in = 1'b1;
      ticks(10);
      chk("bounce_count", 32'(step_count), 32'(c0));
      chk("bounce_level", 32'(btn_level), 32'h0);

      // Randomized segments of presses, halts and mode changes.
      for (int s = 0; s < 30; s++) begin
         len       = int'($urandom_range(1, 14));
         button_in = 1'($urandom_range(0, 1));
         halt_in   = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 5) == 0) run_mode = ~run_mode;
         ticks(len);
      end
      run_mode = 1'b0; halt_in = 1'b0; button_in = 1'b1;
      ticks(25);

      // Auto mode for 100 cycles with a press in the middle.
      c0 = step_count;
      npulse = 0;
      run_mode = 1'b1;
      ticks(40);
      button_in = 1'b0;
      ticks(15);
      button_in = 1'b1;
      ticks(45);
      d = int'(step_count - c0);
      chk("auto_delta_range", 32'(d == 9 || d == 10), 32'h1);
      chk("auto_pulses", 32'(npulse), 32'(d));

      // Halt blocks further auto steps.
      halt_in = 1'b1;
      npulse = 0;
      ticks(40);
      chk("halt_no_pulse", 32'(npulse), 32'h0);

      // Single step still works while halted.
      run_mode = 1'b0;
      ticks(10);
      c0 = step_count;
      button_in = 1'b0;
      ticks(14);
      button_in = 1'b1;
      ticks(12);
      chk("halt_single_step", 32'(step_count), 32'(c0 + 16'd1));
      halt_in = 1'b0;

      // Counter wrap from 0xFFFF.
      force dut.step_count = 16'hFFFF;
      m_cnt = 16'hFFFF;
      tick();
      release dut.step_count;
      tick();
      button_in = 1'b0;
      ticks(14);
      button_in = 1'b1;
      ticks(12);
      chk("wrap_count", 32'(step_count), 32'h0);

      // Reset while step_clk is high.
      button_in = 1'b0;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick();
         if (step_clk === 1'b1) seen = 1;
      end
      chk("reset_mid_found_high", 32'(seen), 32'h1);
      #2;
      Reset = 1'b1;
      model_reset();
      #1;
      chk("reset_async_clk",   32'(step_clk),   32'h0);
      chk("reset_async_busy",  32'(busy),       32'h0);
      chk("reset_async_count", 32'(step_count), 32'h0);
      button_in = 1'b1;
      ticks(3);
      Reset = 1'b0;
      ticks(20);
      chk("no_step_after_reset", 32'(step_count), 32'h0);

      // One more step to show the FSM resumed from IDLE.
      button_in = 1'b0;
      ticks(14);
      button_in = 1'b1;
      ticks(12);
      chk("step_after_reset", 32'(step_count), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
